// File: rtl/riscv_mpsoc_pkg.sv
// Shared AHB-Lite and data-memory definitions for the riscv_mpsoc slice.
package riscv_mpsoc_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B8  = 3'b000;
    localparam logic [2:0] HSIZE_B16 = 3'b001;
    localparam logic [2:0] HSIZE_B32 = 3'b010;
    localparam logic [2:0] HSIZE_B64 = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam int HPROT_DATA_IDX       = 0;
    localparam int HPROT_PRIVILEGED_IDX = 1;

    localparam logic [1:0] DMEM_SIZE_B = 2'd0;
    localparam logic [1:0] DMEM_SIZE_H = 2'd1;
    localparam logic [1:0] DMEM_SIZE_W = 2'd2;
    localparam logic [1:0] DMEM_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'd0,
        DMEM_ST_ADDR = 2'd1,
        DMEM_ST_DATA = 2'd2,
        DMEM_ST_RESP = 2'd3
    } dmem_ahb_state_t;

endpackage

// File: rtl/riscv_dmem_align.sv
// Combinational alignment/size legality check and write-lane shift for one request.
module riscv_dmem_align
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      adr,
    input  logic [1:0]      size,
    input  logic [XLEN-1:0] d,
    output logic            misaligned,
    output logic            illegal,
    output logic [XLEN-1:0] wdata
);

    localparam int ABITS = $clog2(XLEN / 8);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            DMEM_SIZE_B: misaligned = 1'b0;
            DMEM_SIZE_H: misaligned = adr[0];
            DMEM_SIZE_W: misaligned = |adr[1:0];
            DMEM_SIZE_D: misaligned = |adr[2:0];
            default:     misaligned = 1'b0;
        endcase
    end

    // A doubleword cannot be carried on a 32-bit bus.
    assign illegal = (XLEN == 32) && (size == DMEM_SIZE_D);

    assign wdata = d << {adr[ABITS-1:0], 3'b000};

endmodule

// File: rtl/riscv_dmem_ahb.sv
// Data-memory responder: one core load/store at a time, one AHB-Lite SINGLE transfer, one response pulse.
module riscv_dmem_ahb
    import riscv_mpsoc_pkg::*;
#(
    parameter int         XLEN       = 64,
    parameter int         PLEN       = 64,
    parameter logic [3:0] HPROT_DATA = 4'b0011
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            dmem_req_i,
    input  logic [PLEN-1:0] dmem_adr_i,
    input  logic [2:0]      dmem_size_i,
    input  logic            dmem_we_i,
    input  logic [XLEN-1:0] dmem_d_i,
    input  logic            dmem_pagefault_i,
    output logic            dmem_ack_o,
    output logic            dmem_err_o,
    output logic            dmem_misaligned_o,
    output logic            dmem_page_fault_o,
    output logic [XLEN-1:0] dmem_q_o,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] ST_IDLE = DMEM_ST_IDLE;
    localparam logic [1:0] ST_ADDR = DMEM_ST_ADDR;
    localparam logic [1:0] ST_DATA = DMEM_ST_DATA;
    localparam logic [1:0] ST_RESP = DMEM_ST_RESP;

    // Handshake: dmem_req_i is held stable from acceptance in IDLE until the
    // single-cycle response pulse in RESP; AHB transfers advance only on HREADY=1.
    logic [1:0]      state;
    logic            chk_misaligned;
    logic            chk_illegal;
    logic [XLEN-1:0] lane_wdata;
    logic            unused_size_msb;

    assign unused_size_msb = dmem_size_i[2];

    riscv_dmem_align #(
        .XLEN(XLEN)
    ) u_align (
        .adr        (dmem_adr_i[2:0]),
        .size       (dmem_size_i[1:0]),
        .d          (dmem_d_i),
        .misaligned (chk_misaligned),
        .illegal    (chk_illegal),
        .wdata      (lane_wdata)
    );

    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            dmem_ack_o        <= 1'b0;
            dmem_err_o        <= 1'b0;
            dmem_misaligned_o <= 1'b0;
            dmem_page_fault_o <= 1'b0;
            dmem_q_o          <= '0;
            HSEL              <= 1'b0;
            HADDR             <= '0;
            HWDATA            <= '0;
            HWRITE            <= 1'b0;
            HSIZE             <= 3'b000;
            HTRANS            <= HTRANS_IDLE;
        end else begin
            // Pulses live only in the RESP cycle.
            dmem_ack_o        <= 1'b0;
            dmem_err_o        <= 1'b0;
            dmem_misaligned_o <= 1'b0;
            dmem_page_fault_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (dmem_req_i) begin
                        if (dmem_pagefault_i) begin
                            dmem_page_fault_o <= 1'b1;
                            state             <= ST_RESP;
                        end else if (chk_misaligned) begin
                            dmem_misaligned_o <= 1'b1;
                            state             <= ST_RESP;
                        end else if (chk_illegal) begin
                            dmem_err_o <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            HADDR  <= dmem_adr_i;
                            HSIZE  <= {1'b0, dmem_size_i[1:0]};
                            HWRITE <= dmem_we_i;
                            HSEL   <= 1'b1;
                            HTRANS <= HTRANS_NONSEQ;
                            state  <= ST_ADDR;
                        end
                    end
                end

                ST_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        HSEL   <= 1'b0;
                        HWDATA <= lane_wdata;
                        state  <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    // The first ERROR cycle arrives with HREADY=0 and is simply waited out.
                    if (HREADY) begin
                        if (HRESP) begin
                            dmem_err_o <= 1'b1;
                        end else begin
                            dmem_ack_o <= 1'b1;
                            if (!HWRITE) begin
                                dmem_q_o <= HRDATA;
                            end
                        end
                        state <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ahb.sv
// Directed bench for riscv_dmem_ahb (XLEN=64, PLEN=64) with a hand-driven AHB slave.
module tb_riscv_dmem_ahb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dmem_req_i;
    logic [63:0] dmem_adr_i;
    logic [2:0]  dmem_size_i;
    logic        dmem_we_i;
    logic [63:0] dmem_d_i;
    logic        dmem_pagefault_i;
    logic        dmem_ack_o;
    logic        dmem_err_o;
    logic        dmem_misaligned_o;
    logic        dmem_page_fault_o;
    logic [63:0] dmem_q_o;
    logic        HSEL;
    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HRESP;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    riscv_dmem_ahb #(
        .XLEN       (64),
        .PLEN       (64),
        .HPROT_DATA (4'b0011)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .dmem_req_i        (dmem_req_i),
        .dmem_adr_i        (dmem_adr_i),
        .dmem_size_i       (dmem_size_i),
        .dmem_we_i         (dmem_we_i),
        .dmem_d_i          (dmem_d_i),
        .dmem_pagefault_i  (dmem_pagefault_i),
        .dmem_ack_o        (dmem_ack_o),
        .dmem_err_o        (dmem_err_o),
        .dmem_misaligned_o (dmem_misaligned_o),
        .dmem_page_fault_o (dmem_page_fault_o),
        .dmem_q_o          (dmem_q_o),
        .HSEL              (HSEL),
        .HADDR             (HADDR),
        .HWDATA            (HWDATA),
        .HRDATA            (HRDATA),
        .HWRITE            (HWRITE),
        .HSIZE             (HSIZE),
        .HBURST            (HBURST),
        .HPROT             (HPROT),
        .HTRANS            (HTRANS),
        .HMASTLOCK         (HMASTLOCK),
        .HREADY            (HREADY),
        .HRESP             (HRESP)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {ack, err, misaligned, page_fault}
    function automatic logic [3:0] pulses();
        return {dmem_ack_o, dmem_err_o, dmem_misaligned_o, dmem_page_fault_o};
    endfunction

    task automatic request(input logic [63:0] adr, input logic [2:0] size,
                           input logic we, input logic [63:0] d, input logic pf);
        dmem_req_i       = 1'b1;
        dmem_adr_i       = adr;
        dmem_size_i      = size;
        dmem_we_i        = we;
        dmem_d_i         = d;
        dmem_pagefault_i = pf;
    endtask

    initial begin
        rst_i = 1'b1; dmem_req_i = 1'b0; dmem_adr_i = '0; dmem_size_i = '0;
        dmem_we_i = 1'b0; dmem_d_i = '0; dmem_pagefault_i = 1'b0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        step(); step();

        check("rst_state", 64'(dut.state), 64'd0);
        check("rst_pulses", 64'(pulses()), 64'h0);
        check("rst_q", dmem_q_o, 64'h0);
        check("rst_htrans", 64'(HTRANS), 64'h0);
        check("rst_hsel", 64'(HSEL), 64'h0);
        check("rst_haddr", HADDR, 64'h0);
        check("rst_hwdata", HWDATA, 64'h0);
        check("rst_hsize_hwrite", 64'({HSIZE, HWRITE}), 64'h0);
        check("const_hprot", 64'(HPROT), 64'h3);
        check("const_hburst_lock", 64'({HBURST, HMASTLOCK}), 64'h0);
        rst_i = 1'b0;
        step();

        // LD 0x8000_0010, zero-wait slave
        request(64'h8000_0010, 3'd3, 1'b0, 64'h0, 1'b0);
        step();
        check("ld_c1_htrans", 64'(HTRANS), 64'h2);
        check("ld_c1_hsize", 64'(HSIZE), 64'h3);
        check("ld_c1_haddr", HADDR, 64'h8000_0010);
        check("ld_c1_hsel_hwrite", 64'({HSEL, HWRITE}), 64'b10);
        check("ld_c1_pulses", 64'(pulses()), 64'h0);
        HRDATA = 64'h1122334455667788;
        step();
        check("ld_c2_htrans", 64'(HTRANS), 64'h0);
        check("ld_c2_hsel", 64'(HSEL), 64'h0);
        check("ld_c2_pulses", 64'(pulses()), 64'h0);
        step();
        check("ld_c3_pulses", 64'(pulses()), 64'b1000);
        check("ld_c3_q", dmem_q_o, 64'h1122334455667788);
        dmem_req_i = 1'b0;
        HRDATA = 64'h0;
        step();
        check("ld_c4_pulses", 64'(pulses()), 64'h0);
        check("ld_c4_state", 64'(dut.state), 64'd0);

        // SB 0x1003 d=0xA5, two data-phase wait states
        request(64'h1003, 3'd0, 1'b1, 64'hA5, 1'b0);
        step();
        check("sb_c1_htrans", 64'(HTRANS), 64'h2);
        check("sb_c1_hsize_hwrite", 64'({HSIZE, HWRITE}), 64'b0001);
        step();
        check("sb_c2_hwdata", HWDATA, 64'h00000000A5000000);
        check("sb_c2_htrans", 64'(HTRANS), 64'h0);
        HREADY = 1'b0;
        step();
        check("sb_c3_pulses", 64'(pulses()), 64'h0);
        step();
        check("sb_c4_pulses", 64'(pulses()), 64'h0);
        HREADY = 1'b1;
        step();
        check("sb_c5_pulses", 64'(pulses()), 64'b1000);
        check("sb_c5_q_kept", dmem_q_o, 64'h1122334455667788);
        dmem_req_i = 1'b0;
        step();

        // LW 0x1002: misaligned, no bus transfer
        request(64'h1002, 3'd2, 1'b0, 64'h0, 1'b0);
        step();
        check("lw_mis_c1_pulses", 64'(pulses()), 64'b0010);
        check("lw_mis_c1_htrans", 64'(HTRANS), 64'h0);
        dmem_req_i = 1'b0;
        step();
        check("lw_mis_c2_pulses", 64'(pulses()), 64'h0);
        check("lw_mis_c2_htrans", 64'(HTRANS), 64'h0);

        // SW 0x1001 with MMU fault: page fault beats misalignment
        request(64'h1001, 3'd2, 1'b1, 64'hDEAD_BEEF, 1'b1);
        step();
        check("sw_pf_c1_pulses", 64'(pulses()), 64'b0001);
        check("sw_pf_c1_htrans", 64'(HTRANS), 64'h0);
        dmem_req_i = 1'b0;
        dmem_pagefault_i = 1'b0;
        step();
        check("sw_pf_c2_htrans", 64'(HTRANS), 64'h0);

        // LH 0x2000 with two-cycle ERROR response
        request(64'h2000, 3'd1, 1'b0, 64'h0, 1'b0);
        step();
        check("lh_c1_hsize", 64'(HSIZE), 64'h1);
        step();
        HREADY = 1'b0; HRESP = 1'b1; HRDATA = 64'hDEAD;
        step();
        check("lh_c3_pulses", 64'(pulses()), 64'h0);
        HREADY = 1'b1;
        step();
        check("lh_c4_pulses", 64'(pulses()), 64'b0100);
        check("lh_c4_q_kept", dmem_q_o, 64'h1122334455667788);
        dmem_req_i = 1'b0; HRESP = 1'b0; HRDATA = 64'h0;
        step();

        // LD 0x3000, reset while the data phase is stalled
        request(64'h3000, 3'd3, 1'b0, 64'h0, 1'b0);
        step();
        step();
        check("rstmid_c2_state", 64'(dut.state), 64'd2);
        HREADY = 1'b0;
        rst_i = 1'b1;
        step();
        check("rstmid_state", 64'(dut.state), 64'd0);
        check("rstmid_htrans", 64'(HTRANS), 64'h0);
        check("rstmid_pulses", 64'(pulses()), 64'h0);
        check("rstmid_q", dmem_q_o, 64'h0);
        rst_i = 1'b0; dmem_req_i = 1'b0; HREADY = 1'b1;
        step();

        // LD 0x4008 after reset completes normally at +3
        request(64'h4008, 3'd3, 1'b0, 64'h0, 1'b0);
        step();
        check("ld2_c1_htrans", 64'(HTRANS), 64'h2);
        check("ld2_c1_haddr", HADDR, 64'h4008);
        HRDATA = 64'h0123456789ABCDEF;
        step();
        check("ld2_c2_pulses", 64'(pulses()), 64'h0);
        step();
        check("ld2_c3_pulses", 64'(pulses()), 64'b1000);
        check("ld2_c3_q", dmem_q_o, 64'h0123456789ABCDEF);
        dmem_req_i = 1'b0;
        step();
        check("ld2_c4_pulses", 64'(pulses()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
